ysyx_23060020_lsu: RTL and testbench

Load/store unit that sits directly upstream of ysyx_23060020_mem and drives its memvalid/wen/wmask/mem_add/mem_data inputs. It accepts one load or store at a time from EXU over a valid/ready handshake. It builds byte-lane masks and replicated store data, then extracts and sign/zero-extends load data from mem_outdata. It returns the result to WBU over a valid/ready handshake, with a configurable modelled memory latency.

---
 rtl/ysyx_23060020_lsu.sv | 176 +++++++++++++++++
 tb/tb_ysyx_23060020_lsu.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060020_lsu.sv
// ysyx_23060020_lsu: single-outstanding load/store unit in front of ysyx_23060020_mem.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module ysyx_23060020_lsu #(
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        memvalid,
  output logic        wen,
  output logic [3:0]  wmask,
  output logic [31:0] mem_add,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_outdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic       HAS_WAIT = (MEM_LATENCY > 0);
  localparam logic [3:0] LAT_M1   = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_wen;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [3:0]  r_cnt;
  logic        r_err;

  logic        w_mis;
  logic [1:0]  w_off;
  logic [3:0]  w_smask;
  logic [31:0] w_sdata;
  logic [31:0] w_bsh;
  logic [31:0] w_hsh;
  logic [31:0] w_load;
  logic [31:0] w_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1] && req_addr[1:0] != 2'b00);
`else
  assign w_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = w_mis ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = HAS_WAIT ? S_WAIT : S_RESP;
      S_WAIT:   if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (rst) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen   <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_wen   <= req_wen;
      r_f3    <= req_funct3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_err   <= w_mis;
    end
  end

  // Memory read data is combinational, so capture it on the access cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= 32'd0;
      r_cnt  <= 4'd0;
    end else begin
      if (r_state == S_ACCESS) r_word <= mem_outdata;
      if (r_state == S_ACCESS) r_cnt <= LAT_M1;
      else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  assign w_off = r_addr[1:0];

  always_comb begin
    w_smask = 4'b1111;
    w_sdata = r_wdata;
    case (r_f3[1:0])
      2'b00: begin
        w_smask = 4'b0001 << w_off;
        w_sdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_smask = r_addr[1] ? 4'b1100 : 4'b0011;
        w_sdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_smask = 4'b1111;
        w_sdata = r_wdata;
      end
    endcase
  end

  assign w_bsh = r_word >> {w_off, 3'b000};
  assign w_hsh = r_word >> {r_addr[1], 4'b0000};

  always_comb begin
    w_load = r_word;
    case (r_f3)
      3'b000:  w_load = {{24{w_bsh[7]}}, w_bsh[7:0]};
      3'b100:  w_load = {24'd0, w_bsh[7:0]};
      3'b001:  w_load = {{16{w_hsh[15]}}, w_hsh[15:0]};
      3'b101:  w_load = {16'd0, w_hsh[15:0]};
      default: w_load = r_word;
    endcase
  end

  assign w_rdata = (r_wen || r_err) ? 32'd0 : w_load;

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    memvalid   = 1'b0;
    wen        = 1'b0;
    wmask      = 4'd0;
    mem_add    = 32'd0;
    mem_data   = 32'd0;
    if (rst) begin
      req_ready = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: req_ready = 1'b1;
        S_ACCESS: begin
          memvalid = 1'b1;
          wen      = r_wen;
          mem_add  = {r_addr[31:2], 2'b00};
          wmask    = r_wen ? w_smask : 4'd0;
          mem_data = r_wen ? w_sdata : 32'd0;
        end
        S_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = w_rdata;
          resp_err   = r_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060020_lsu.sv
// Scoreboard bench for ysyx_23060020_lsu at latencies 0 and 3.
// The same directed requests drive both instances in lockstep.
module tb_ysyx_23060020_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        rq [2];
  logic        rv [2];
  logic        re [2];
  logic        mv [2];
  logic        we [2];
  logic        rr [2];
  logic [3:0]  wm [2];
  logic [31:0] rd [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [31:0] mo [2];
  logic [31:0] mem [2][16];

  int cyc = 0;
  int nc = 0;
  int nf = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        direct;
    int          acc;
    int          hold;
  } rexp_t;

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] data;
    int          acc;
  } mexp_t;

  rexp_t qr [2][$];
  mexp_t qm [2][$];

  ysyx_23060020_lsu #(.MEM_LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rq[0]),
    .req_wen(req_wen), .req_funct3(f3), .req_addr(addr),
    .req_wdata(wdata), .resp_valid(rv[0]), .resp_ready(rr[0]),
    .resp_rdata(rd[0]), .resp_err(re[0]), .memvalid(mv[0]),
    .wen(we[0]), .wmask(wm[0]), .mem_add(ma[0]), .mem_data(md[0]),
    .mem_outdata(mo[0])
  );

  ysyx_23060020_lsu #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rq[1]),
    .req_wen(req_wen), .req_funct3(f3), .req_addr(addr),
    .req_wdata(wdata), .resp_valid(rv[1]), .resp_ready(rr[1]),
    .resp_rdata(rd[1]), .resp_err(re[1]), .memvalid(mv[1]),
    .wen(we[1]), .wmask(wm[1]), .mem_add(ma[1]), .mem_data(md[1]),
    .mem_outdata(mo[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  assign mo[0] = mem[0][ma[0][5:2]];
  assign mo[1] = mem[1][ma[1][5:2]];

  initial begin
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 16; i++) mem[g][i] <= 32'd0;
      mem[g][0] <= 32'h80FF7F01;
      mem[g][1] <= 32'hDEADBEEF;
      mem[g][4] <= 32'h11223344;
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (mv[g] && we[g])
        for (int b = 0; b < 4; b++)
          if (wm[g][b]) mem[g][ma[g][5:2]][b*8 +: 8] <= md[g][b*8 +: 8];
  end

  function automatic void chk(int g, string nm, logic [31:0] act, logic [31:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s (dut %0d): got %h expected %h", nm, g, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int L = (g == 0) ? 0 : 3;
    bit seen = 0;
    int cnt = 0;

    always @(negedge clk) begin
      mexp_t m;
      if (mv[g]) begin
        if (qm[g].size() == 0) begin
          nc++;
          nf++;
          $display("FAIL mem_unexpected (dut %0d): got add %h expected none", g, ma[g]);
        end else begin
          m = qm[g].pop_front();
          chk(g, "mem_add", ma[g], m.add);
          chk(g, "mem_wen", 32'(we[g]), 32'(m.wen));
          chk(g, "mem_wmask", 32'(wm[g]), 32'(m.wmask));
          chk(g, "mem_data", md[g], m.data);
          chk(g, "mem_cycle", cyc, m.acc + 1);
        end
      end
    end

    initial begin
      rexp_t e;
      rr[g] = 1'b0;
      forever begin
        @(negedge clk);
        if (rr[g]) rr[g] = 1'b0;
        if (rv[g]) begin
          if (qr[g].size() == 0) begin
            nc++;
            nf++;
            $display("FAIL resp_unexpected (dut %0d): got data %h expected none", g, rd[g]);
          end else begin
            e = qr[g][0];
            if (!seen) begin
              chk(g, "resp_latency", cyc, e.acc + (e.direct ? 1 : 2 + L));
              chk(g, "resp_rdata", rd[g], e.rdata);
              chk(g, "resp_err", 32'(re[g]), 32'(e.err));
              seen = 1;
              cnt = 0;
            end else begin
              chk(g, "hold_rdata", rd[g], e.rdata);
              chk(g, "hold_req_ready", 32'(rq[g]), 32'd0);
              cnt++;
            end
            if (cnt >= e.hold) begin
              rr[g] = 1'b1;
              void'(qr[g].pop_front());
              seen = 0;
            end
          end
        end else if (seen) begin
          nc++;
          nf++;
          $display("FAIL resp_dropped (dut %0d): got valid 0 expected 1", g);
          seen = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (rq[0] && rq[1] && qr[0].size() == 0 && qr[1].size() == 0 &&
          qm[0].size() == 0 && qm[1].size() == 0)
        return;
      @(negedge clk);
    end
    nc++;
    nf++;
    $display("FAIL idle_timeout: got busy expected idle within 200 cycles");
  endtask

  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic mis, input logic [31:0] rdat,
                       input int hold, input logic [3:0] mmask, input logic [31:0] mdata);
    rexp_t e;
    mexp_t m;
    logic  trap;
    wait_idle();
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    e.rdata  = trap ? 32'd0 : rdat;
    e.err    = trap;
    e.direct = trap;
    e.acc    = cyc;
    e.hold   = hold;
    m.add    = {a[31:2], 2'b00};
    m.wen    = w;
    m.wmask  = mmask;
    m.data   = mdata;
    m.acc    = cyc;
    for (int g = 0; g < 2; g++) begin
      qr[g].push_back(e);
      if (!trap) qm[g].push_back(m);
    end
    req_valid = 1'b1;
    req_wen   = w;
    f3        = f;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    f3        = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(g, "rst_req_ready", 32'(rq[g]), 32'd1);
      chk(g, "rst_resp_valid", 32'(rv[g]), 32'd0);
      chk(g, "rst_memvalid", 32'(mv[g]), 32'd0);
      chk(g, "rst_wen", 32'(we[g]), 32'd0);
      chk(g, "rst_wmask", 32'(wm[g]), 32'd0);
      chk(g, "rst_mem_add", ma[g], 32'd0);
      chk(g, "rst_mem_data", md[g], 32'd0);
      chk(g, "rst_rdata", rd[g], 32'd0);
      chk(g, "rst_err", 32'(re[g]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 3'b010, 32'h80000004, 32'd0, 0, 32'hDEADBEEF, 0, 4'd0, 32'd0);
    issue(0, 3'b000, 32'h80000003, 32'd0, 0, 32'hFFFFFF80, 0, 4'd0, 32'd0);
    issue(0, 3'b100, 32'h80000003, 32'd0, 0, 32'h00000080, 0, 4'd0, 32'd0);
    issue(0, 3'b001, 32'h80000002, 32'd0, 0, 32'hFFFF80FF, 0, 4'd0, 32'd0);
    issue(0, 3'b101, 32'h80000000, 32'd0, 0, 32'h00007F01, 0, 4'd0, 32'd0);
    issue(0, 3'b000, 32'h80000001, 32'd0, 0, 32'h0000007F, 0, 4'd0, 32'd0);
    issue(1, 3'b000, 32'h80000009, 32'h123456AB, 0, 32'd0, 0, 4'b0010, 32'hABABABAB);
    issue(1, 3'b001, 32'h8000000A, 32'h123456AB, 0, 32'd0, 0, 4'b1100, 32'h56AB56AB);
    issue(0, 3'b010, 32'h80000008, 32'd0, 0, 32'h56ABAB00, 0, 4'd0, 32'd0);
    issue(1, 3'b010, 32'h8000000C, 32'hCAFEF00D, 0, 32'd0, 0, 4'b1111, 32'hCAFEF00D);
    issue(0, 3'b110, 32'h8000000C, 32'd0, 0, 32'hCAFEF00D, 0, 4'd0, 32'd0);
    issue(1, 3'b011, 32'h80000014, 32'h01020304, 0, 32'd0, 0, 4'b1111, 32'h01020304);
    issue(0, 3'b010, 32'h80000014, 32'd0, 0, 32'h01020304, 0, 4'd0, 32'd0);
    issue(0, 3'b010, 32'h80000004, 32'd0, 0, 32'hDEADBEEF, 5, 4'd0, 32'd0);

    wait_idle();
    req_valid = 1'b1;
    req_wen   = 1'b1;
    f3        = 3'b010;
    addr      = 32'h80000010;
    wdata     = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(g, "rstacc_memvalid", 32'(mv[g]), 32'd0);
      chk(g, "rstacc_wen", 32'(we[g]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(g, "rstacc_resp_valid", 32'(rv[g]), 32'd0);
      chk(g, "rstacc_req_ready", 32'(rq[g]), 32'd1);
    end
    @(negedge clk);
    issue(0, 3'b010, 32'h80000010, 32'd0, 0, 32'h11223344, 0, 4'd0, 32'd0);

    issue(0, 3'b010, 32'h80000002, 32'd0, 1, 32'h80FF7F01, 0, 4'd0, 32'd0);
    issue(0, 3'b101, 32'h80000003, 32'd0, 1, 32'h000080FF, 0, 4'd0, 32'd0);
    issue(0, 3'b000, 32'h80000002, 32'd0, 0, 32'hFFFFFFFF, 2, 4'd0, 32'd0);

    wait_idle();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk(g, "pending_resp", 32'(qr[g].size()), 32'd0);
      chk(g, "pending_mem", 32'(qm[g].size()), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
